divider_4bit: RTL and testbench

Sequential unsigned restoring divider: the inverse of the team's combinational 4-bit array multiplier. It takes a WIDTH-bit dividend and divisor through a valid/ready input handshake and produces the quotient and remainder one bit per clock. Results are returned through a valid/ready output handshake. It sits beside the multiplier in the CombinationalCircuit arithmetic group and uses the same Adder4Bit-style subtract datapath width.

---
 rtl/divider_4bit.sv | 150 +++++++++++++++
 tb/tb_divider_4bit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/divider_4bit.sv
// divider_4bit
// Sequential unsigned restoring divider. A dividend/divisor pair is accepted
// through a valid/ready handshake. Quotient and remainder are then produced one
// bit per clock. The result is held until it is taken through a second
// valid/ready handshake. A zero divisor skips the iteration and goes straight to
// the result, which is then quotient = all ones, remainder = dividend, and the
// divByZero flag set.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous, active-high; returns to IDLE
//   io_in_valid   pair offered            io_in_ready   accepting (IDLE only)
//   io_dividend   unsigned dividend       io_divisor    unsigned divisor
//   io_out_valid  result held (DONE)      io_out_ready  consumer takes result
//   io_quotient   unsigned quotient       io_remainder  unsigned remainder
//   io_divByZero  result came from a zero divisor
// Result ports read 0 outside DONE.
module divider_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_dividend,
  input  logic [WIDTH-1:0] io_divisor,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_quotient,
  output logic [WIDTH-1:0] io_remainder,
  output logic             io_divByZero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             dbz, dbz_nx;

  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH:0]   r_q;

  logic             accept;
  logic [WIDTH+1:0] trial;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH:0]   r_next;

  // Trial subtraction of the divisor from the shifted partial remainder. The
  // result is one bit wider than the operands, so its MSB is the borrow.
  function automatic logic [WIDTH+1:0] trial_sub(input logic [WIDTH+1:0] t,
                                                 input logic [WIDTH-1:0] d);
    return t - {2'b00, d};
  endfunction

  assign io_in_ready  = (state == IDLE) && !reset;
  assign accept       = io_in_valid && io_in_ready;

  // The working remainder stays below the divisor, so r_q[WIDTH] is always 0.
  // Widening T with it keeps the borrow at a fixed bit position.
  assign trial  = {r_q, q_q[WIDTH-1]};
  assign diff   = trial_sub(trial, d_q);
  assign borrow = diff[WIDTH+1];
  assign r_next = borrow ? trial[WIDTH:0] : diff[WIDTH:0];

  // Control state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      dbz   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      dbz   <= dbz_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dbz_nx   = dbz;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx = '0;
          if (io_divisor == '0) begin
            dbz_nx   = 1'b1;
            state_nx = DONE;
          end else begin
            dbz_nx   = 1'b0;
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == LAST_STEP) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (io_out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers. These are only observable in DONE, so they need no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      d_q <= io_divisor;
      if (io_divisor == '0) begin
        q_q <= '1;
        r_q <= {1'b0, io_dividend};
      end else begin
        q_q <= io_dividend;
        r_q <= '0;
      end
    end else if (state == BUSY) begin
      r_q <= r_next;
      q_q <= {q_q[WIDTH-2:0], ~borrow};
    end
  end

  // Result ports
  always_comb begin
    io_out_valid = 1'b0;
    io_quotient  = '0;
    io_remainder = '0;
    io_divByZero = 1'b0;
    if (state == DONE) begin
      io_out_valid = 1'b1;
      io_quotient  = q_q;
      io_remainder = r_q[WIDTH-1:0];
      io_divByZero = dbz;
    end
  end

endmodule

// File: tb/tb_divider_4bit.sv
// Directed and exhaustive bench for divider_4bit at WIDTH = 4.
module tb_divider_4bit;

  logic       clock;
  logic       reset;
  logic       io_in_valid;
  logic       io_in_ready;
  logic [3:0] io_dividend;
  logic [3:0] io_divisor;
  logic       io_out_valid;
  logic       io_out_ready;
  logic [3:0] io_quotient;
  logic [3:0] io_remainder;
  logic       io_divByZero;

  int tests;
  int fails;

  divider_4bit #(.WIDTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_dividend  (io_dividend),
    .io_divisor   (io_divisor),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_quotient  (io_quotient),
    .io_remainder (io_remainder),
    .io_divByZero (io_divByZero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ovalid"}, 32'(io_out_valid), 32'd0);
    chk({tag, "_q0"}, 32'(io_quotient), 32'd0);
    chk({tag, "_r0"}, 32'(io_remainder), 32'd0);
    chk({tag, "_z0"}, 32'(io_divByZero), 32'd0);
  endtask

  // Offer one pair with io_out_ready high and check the latency, the result and
  // the return to IDLE. lat is the number of edges from the accept edge to the
  // first sample where io_out_valid is seen high.
  task automatic do_div(input string tag, input logic [3:0] dvd, input logic [3:0] dsr,
                        input logic [3:0] eq, input logic [3:0] er, input logic ez,
                        input int lat);
    chk({tag, "_inrdy"}, 32'(io_in_ready), 32'd1);
    io_dividend  = dvd;
    io_divisor   = dsr;
    io_in_valid  = 1'b1;
    io_out_ready = 1'b1;
    tick();
    io_in_valid = 1'b0;
    io_dividend = 4'h0;
    io_divisor  = 4'h0;
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) tick();
      chk({tag, "_lat"}, 32'(io_out_valid), (k == lat) ? 32'd1 : 32'd0);
    end
    chk({tag, "_q"}, 32'(io_quotient), 32'(eq));
    chk({tag, "_r"}, 32'(io_remainder), 32'(er));
    chk({tag, "_z"}, 32'(io_divByZero), 32'(ez));
    tick();
    chk({tag, "_back"}, 32'(io_in_ready), 32'd1);
    chk_idle_outputs(tag);
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_dividend  = 4'h0;
    io_divisor   = 4'h0;
    io_out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_inrdy", 32'(io_in_ready), 32'd0);
    chk_idle_outputs("rst");
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_rel_inrdy", 32'(io_in_ready), 32'd1);
    chk_idle_outputs("rst_rel");

    // Basic and boundary operands
    do_div("d13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 4);
    do_div("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4);
    do_div("d3_5", 4'd3, 4'd5, 4'd0, 4'd3, 1'b0, 4);
    do_div("d15_15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 4);

    // Divide by zero goes to DONE on the accept edge itself
    do_div("d7_0", 4'd7, 4'd0, 4'd15, 4'd7, 1'b1, 0);
    do_div("d8_2", 4'd8, 4'd2, 4'd4, 4'd0, 1'b0, 4);

    // Backpressure: 9/2 held while io_out_ready is low and inputs wiggle
    io_out_ready = 1'b0;
    io_dividend  = 4'd9;
    io_divisor   = 4'd2;
    io_in_valid  = 1'b1;
    tick();
    io_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("bp_valid", 32'(io_out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      io_in_valid = 1'b1;
      io_dividend = 4'(k + 3);
      io_divisor  = 4'(k);
      tick();
      chk("bp_hold_valid", 32'(io_out_valid), 32'd1);
      chk("bp_hold_q", 32'(io_quotient), 32'd4);
      chk("bp_hold_r", 32'(io_remainder), 32'd1);
      chk("bp_hold_z", 32'(io_divByZero), 32'd0);
      chk("bp_hold_inrdy", 32'(io_in_ready), 32'd0);
    end
    io_in_valid  = 1'b0;
    io_out_ready = 1'b1;
    tick();
    chk("bp_done_inrdy", 32'(io_in_ready), 32'd1);
    chk_idle_outputs("bp_done");

    // Reset two edges after accepting 14/3
    io_out_ready = 1'b1;
    io_dividend  = 4'd14;
    io_divisor   = 4'd3;
    io_in_valid  = 1'b1;
    tick();
    io_in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_inrdy", 32'(io_in_ready), 32'd0);
    chk_idle_outputs("mid_rst");
    tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("mid_rst_noval", 32'(io_out_valid), 32'd0);
    end
    do_div("d14_3", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 4);

    // Exhaustive pairs with random valid/ready gaps
    begin
      int idx_in;
      int idx_out;
      int cyc;
      logic [3:0] ed;
      logic [3:0] es;
      logic [3:0] eq;
      logic [3:0] er;
      logic       ez;
      idx_in  = 0;
      idx_out = 0;
      cyc     = 0;
      io_in_valid  = 1'b0;
      io_out_ready = 1'b0;
      while (idx_out < 256 && cyc < 20000) begin
        if (io_out_valid && io_out_ready) begin
          ed = 4'(idx_out >> 4);
          es = 4'(idx_out);
          if (es == 4'd0) begin
            eq = 4'hF;
            er = ed;
            ez = 1'b1;
          end else begin
            eq = ed / es;
            er = ed % es;
            ez = 1'b0;
          end
          chk("ex_q", {24'(idx_out), 4'h0, io_quotient}, {24'(idx_out), 4'h0, eq});
          chk("ex_r", {24'(idx_out), 4'h0, io_remainder}, {24'(idx_out), 4'h0, er});
          chk("ex_z", {24'(idx_out), 7'h0, io_divByZero}, {24'(idx_out), 7'h0, ez});
          idx_out++;
        end
        if (io_in_valid && io_in_ready) idx_in++;
        tick();
        cyc++;
        io_in_valid  = (idx_in < 256) && ($urandom_range(3) != 0);
        io_dividend  = 4'(idx_in >> 4);
        io_divisor   = 4'(idx_in);
        io_out_ready = ($urandom_range(2) != 0);
      end
      chk("ex_all_out", 32'(idx_out), 32'd256);
      chk("ex_all_in", 32'(idx_in), 32'd256);
      io_in_valid  = 1'b0;
      io_out_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
